vx_dispatch_rr_arbiter: RTL

//  Shares one execute-unit dispatch port (e.g. SFU) among ISSUE_CNT issue slots with

---
 rtl/vx_dispatch_rr_arbiter_if.sv | 27 ++
 rtl/vx_dispatch_rr_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vx_dispatch_rr_arbiter_if.sv
// Dispatch bundle between ISSUE_CNT issue slots, the round-robin arbiter and one
// execute-unit input port.
interface vx_dispatch_rr_arbiter_if #(
    parameter int ISSUE_CNT = 4,
    parameter int DATA_W    = 64
);
    localparam int SLOT_W = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;

    logic [ISSUE_CNT-1:0]        flush;
    logic [ISSUE_CNT-1:0]        req_valid;
    logic [ISSUE_CNT*DATA_W-1:0] req_data;
    logic [ISSUE_CNT-1:0]        req_ready;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic [SLOT_W-1:0]           out_slot;
    logic                        out_ready;

    // master: issue slots plus the execute unit; slave: the arbiter
    modport master (
        output flush, req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_slot
    );
    modport slave (
        input  flush, req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_slot
    );
endinterface

// File: rtl/vx_dispatch_rr_arbiter.sv
// Round-robin arbiter funnelling ISSUE_CNT issue-slot dispatch requests into one
// registered, flushable output entry that feeds a single execute unit.

module vx_dispatch_rr_lane #(
    parameter int SLOT_W = 2,
    parameter int IDX    = 0
) (
    input  logic              req_valid,
    input  logic              flush,
    input  logic [SLOT_W-1:0] rr_ptr,
    output logic              elig,
    output logic              elig_hi
);
    assign elig    = req_valid & ~flush;
    // slots at or past the pointer win before the wrapped-around ones
    assign elig_hi = elig & (SLOT_W'(IDX) >= rr_ptr);
endmodule

module vx_dispatch_rr_arbiter #(
    parameter int ISSUE_CNT = 4,
    parameter int DATA_W    = 64,
    parameter int PERF_W    = 44
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_dispatch_rr_arbiter_if.slave bus,
    output logic [PERF_W-1:0]       perf_stalls
);
    localparam int SLOT_W = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(ISSUE_CNT - 1);

    typedef struct packed {
        logic              vld;
        logic [SLOT_W-1:0] slot;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                           ent;
    logic [SLOT_W-1:0]                rr_ptr;
    logic [ISSUE_CNT-1:0][DATA_W-1:0] req_data_a;
    logic [ISSUE_CNT-1:0]             elig, elig_hi, gnt_oh;
    logic [SLOT_W-1:0]                hi_idx, lo_idx, gnt_idx;
    logic                             hi_any, lo_any, gnt_any;
    logic                             ent_flushed, out_valid, free, stall;
    logic [DATA_W-1:0]                gnt_data;

    assign req_data_a = bus.req_data;

    for (genvar i = 0; i < ISSUE_CNT; i++) begin : g_lane
        vx_dispatch_rr_lane #(.SLOT_W(SLOT_W), .IDX(i)) u_lane (
            .req_valid (bus.req_valid[i]),
            .flush     (bus.flush[i]),
            .rr_ptr    (rr_ptr),
            .elig      (elig[i]),
            .elig_hi   (elig_hi[i])
        );
    end

    always_comb begin
        ent_flushed = 1'b0;
        for (int i = 0; i < ISSUE_CNT; i++)
            if (ent.slot == SLOT_W'(i) && bus.flush[i]) ent_flushed = 1'b1;
    end

    // a flushed entry is hidden from the unit and frees the stage this same cycle
    assign out_valid = ent.vld & ~ent_flushed;
    assign free      = ~out_valid | bus.out_ready;

    always_comb begin
        hi_idx = '0;
        hi_any = 1'b0;
        lo_idx = '0;
        lo_any = 1'b0;
        for (int i = ISSUE_CNT - 1; i >= 0; i--) begin
            if (elig_hi[i]) begin
                hi_idx = SLOT_W'(i);
                hi_any = 1'b1;
            end
            if (elig[i]) begin
                lo_idx = SLOT_W'(i);
                lo_any = 1'b1;
            end
        end
        gnt_any = free & lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt_oh   = '0;
        gnt_data = '0;
        for (int i = 0; i < ISSUE_CNT; i++) begin
            if (gnt_idx == SLOT_W'(i)) begin
                gnt_oh[i] = gnt_any;
                gnt_data  = req_data_a[i];
            end
        end
    end

    assign stall         = |(elig & ~gnt_oh);
    assign bus.req_ready = gnt_oh;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = ent.data;
    assign bus.out_slot  = ent.slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent         <= '0;
            rr_ptr      <= '0;
            perf_stalls <= '0;
        end else begin
            if (gnt_any) begin
                ent.vld  <= 1'b1;
                ent.slot <= gnt_idx;
                ent.data <= gnt_data;
                // explicit wrap keeps non-power-of-2 slot counts in range
                rr_ptr   <= (gnt_idx == LAST_SLOT) ? '0 : gnt_idx + SLOT_W'(1);
            end else if ((out_valid & bus.out_ready) | ent_flushed) begin
                ent.vld <= 1'b0;
            end
            if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + PERF_W'(1);
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.req_ready));

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !bus.out_ready) |=> ($stable(ent.data) && $stable(ent.slot)));
endmodule
